// File: rtl/cp0_unit_pkg.sv
// Shared CP0 constants: register numbers, exception codes and Status/Cause bit positions.
package cp0_unit_pkg;

  // mfc0/mtc0 register numbers
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

  // Exception codes that capture a bad address
  localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
  localparam logic [4:0] EXC_CODE_ADES = 5'd5;

  // Status bit positions
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_BEV   = 22;

  // Cause bit positions
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_TI     = 30;
  localparam int unsigned CAUSE_BD     = 31;

  // Address-error exceptions are the only ones that load BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_CODE_ADEL) || (code == EXC_CODE_ADES);
  endfunction

endpackage

// File: rtl/cp0_unit_timer.sv
// CP0 timer: Count prescaler, Count, Compare and the sticky timer-interrupt flag.
module cp0_unit_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam logic [3:0] DivMax = 4'(COUNT_DIV - 1);

  logic [3:0]  r_presc;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_inc;
  logic [31:0] w_count_next;

  assign w_inc        = (r_presc == DivMax);
  assign w_count_next = r_count + 32'd1;

  // Prescaler/Count advance; Compare write clears TI and beats a same-cycle match
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (i_count_we) begin
        r_count <= i_wdata;
        r_presc <= '0;
      end else if (w_inc) begin
        r_count <= w_count_next;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 4'd1;
      end

      if (i_compare_we) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if (w_inc && !i_count_we && (w_count_next == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file for the MEM stage: Status/Cause/EPC/BadVAddr, exception/eret/mtc0
// priority, interrupt request and the mfc0 read mux.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [4:0]            i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [4:0]            i_raddr,
  output logic [31:0]           o_rdata,
  input  logic [NUM_HW_INT-1:0] i_hw_int,
  input  logic                  i_exc_valid,
  input  logic [4:0]            i_exc_code,
  input  logic [31:0]           i_exc_pc,
  input  logic                  i_exc_bd,
  input  logic [31:0]           i_exc_badvaddr,
  input  logic                  i_eret,
  output logic [31:0]           o_status,
  output logic [31:0]           o_cause,
  output logic [31:0]           o_epc,
  output logic                  o_int_req
);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [1:0]  r_sw_ip;
  logic [5:0]  r_hw_ip;
  logic [4:0]  r_exc_code;
  logic        r_bd;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [5:0]  w_hw_ext;
  logic [7:0]  w_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;

  assign w_wr_count   = i_we && (i_waddr == CP0_REG_COUNT);
  assign w_wr_compare = i_we && (i_waddr == CP0_REG_COMPARE);
  assign w_wr_status  = i_we && (i_waddr == CP0_REG_STATUS);
  assign w_wr_cause   = i_we && (i_waddr == CP0_REG_CAUSE);
  assign w_wr_epc     = i_we && (i_waddr == CP0_REG_EPC);

  cp0_unit_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_count_we   (w_wr_count),
    .i_compare_we (w_wr_compare),
    .i_wdata      (i_wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  // Zero-extend the interrupt lines to the six IP[7:2] slots
  always_comb begin
    w_hw_ext                 = '0;
    w_hw_ext[NUM_HW_INT-1:0] = i_hw_int;
  end

  // Per-field update; exception beats eret beats mtc0 only where they touch the same field
  always_ff @(posedge clk) begin
    if (rst) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_sw_ip    <= '0;
      r_hw_ip    <= '0;
      r_exc_code <= '0;
      r_bd       <= 1'b0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      r_hw_ip <= w_hw_ext;

      if (w_wr_cause) r_sw_ip <= i_wdata[CAUSE_IP_LO+:2];

      if (w_wr_status) begin
        r_im <= i_wdata[STATUS_IM_LO+:8];
        r_ie <= i_wdata[STATUS_IE];
      end

      if (i_exc_valid)      r_exl <= 1'b1;
      else if (i_eret)      r_exl <= 1'b0;
      else if (w_wr_status) r_exl <= i_wdata[STATUS_EXL];

      if (i_exc_valid) r_exc_code <= i_exc_code;

      // EPC/BD stay frozen for nested exceptions taken while EXL is set
      if (i_exc_valid && !r_exl) begin
        r_epc <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
        r_bd  <= i_exc_bd;
      end else if (w_wr_epc) begin
        r_epc <= i_wdata;
      end

      if (i_exc_valid && is_addr_exc(i_exc_code)) r_badvaddr <= i_exc_badvaddr;
    end
  end

  assign w_ip = {r_hw_ip[5] | w_ti, r_hw_ip[4:0], r_sw_ip};

  // Assemble architectural Status and Cause views
  always_comb begin
    w_status                    = '0;
    w_status[STATUS_IE]         = r_ie;
    w_status[STATUS_EXL]        = r_exl;
    w_status[STATUS_IM_LO+:8]   = r_im;
    w_status[STATUS_BEV]        = 1'b1;
    w_cause                     = '0;
    w_cause[CAUSE_EXC_LO+:5]    = r_exc_code;
    w_cause[CAUSE_IP_LO+:8]     = w_ip;
    w_cause[CAUSE_TI]           = w_ti;
    w_cause[CAUSE_BD]           = r_bd;
  end

  // mfc0 read mux; unmapped registers read as zero
  always_comb begin
    o_rdata = '0;
    case (i_raddr)
      CP0_REG_BADVADDR: o_rdata = r_badvaddr;
      CP0_REG_COUNT:    o_rdata = w_count;
      CP0_REG_COMPARE:  o_rdata = w_compare;
      CP0_REG_STATUS:   o_rdata = w_status;
      CP0_REG_CAUSE:    o_rdata = w_cause;
      CP0_REG_EPC:      o_rdata = r_epc;
      CP0_REG_PRID:     o_rdata = PRID_VAL;
      CP0_REG_CONFIG:   o_rdata = CONFIG_VAL;
      default:          o_rdata = '0;
    endcase
  end

  assign o_status  = w_status;
  assign o_cause   = w_cause;
  assign o_epc     = r_epc;
  assign o_int_req = r_ie && !r_exl && (|(r_im & w_ip));

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: reset table, directed corner sequences, then random traffic
// against a cycle-level behavioural model.
module tb_cp0_unit;

  localparam int unsigned DIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        int_req;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp0_unit #(
    .NUM_HW_INT (6),
    .COUNT_DIV  (DIV),
    .PRID_VAL   (32'h004c_0102),
    .CONFIG_VAL (32'h0000_8000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_we           (we),
    .i_waddr        (waddr),
    .i_wdata        (wdata),
    .i_raddr        (raddr),
    .o_rdata        (rdata),
    .i_hw_int       (hw_int),
    .i_exc_valid    (exc_valid),
    .i_exc_code     (exc_code),
    .i_exc_pc       (exc_pc),
    .i_exc_bd       (exc_bd),
    .i_exc_badvaddr (exc_badvaddr),
    .i_eret         (eret),
    .o_status       (status_o),
    .o_cause        (cause_o),
    .o_epc          (epc_o),
    .o_int_req      (int_req)
  );

  // ---------------- behavioural model ----------------
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [1:0]  m_sw;
  logic [5:0]  m_hw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bva, m_count, m_compare;
  int          m_elapsed;  // clock edges since reset or last Count write

  function automatic logic [31:0] m_status();
    return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'b0, m_hw[5] | m_ti, m_hw[4:0], m_sw, 1'b0, m_code, 2'b0};
  endfunction

  function automatic logic m_int_req();
    logic [31:0] c;
    c = m_cause();
    return m_ie && !m_exl && (|(m_im & c[15:8]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bva;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return 32'h004c_0102;
      5'd16:   return 32'h0000_8000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_sw = 0; m_hw = 0;
    m_code = 0; m_epc = 0; m_bva = 0; m_count = 0; m_compare = 0; m_elapsed = 0;
  endtask

  // Next state from the inputs currently driven, all derived from old state
  task automatic model_edge();
    logic wr_st, wr_ca, wr_ep, wr_cnt, wr_cmp, ticks, hit;
    wr_st  = we && waddr == 5'd12;
    wr_ca  = we && waddr == 5'd13;
    wr_ep  = we && waddr == 5'd14;
    wr_cnt = we && waddr == 5'd9;
    wr_cmp = we && waddr == 5'd11;
    ticks  = !wr_cnt && ((m_elapsed + 1) % DIV == 0);
    hit    = ticks && (m_count + 32'd1 == m_compare);
    if (wr_cmp) m_ti = 0;
    else if (hit) m_ti = 1;
    if (wr_cmp) m_compare = wdata;
    if (wr_cnt) begin m_count = wdata; m_elapsed = 0; end
    else begin m_elapsed++; if (ticks) m_count = m_count + 32'd1; end
    m_hw = hw_int;
    if (wr_ca) m_sw = wdata[9:8];
    if (wr_st) begin m_im = wdata[15:8]; m_ie = wdata[0]; end
    if (exc_valid) begin
      if (!m_exl) begin m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc; m_bd = exc_bd; end
      else if (wr_ep) m_epc = wdata;
      m_code = exc_code;
      if (exc_code == 5'd4 || exc_code == 5'd5) m_bva = exc_badvaddr;
    end else if (wr_ep) m_epc = wdata;
    if (exc_valid) m_exl = 1;
    else if (eret) m_exl = 0;
    else if (wr_st) m_exl = wdata[1];
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; exc_valid = 0; exc_code = 0; exc_pc = 0;
    exc_bd = 0; exc_badvaddr = 0; eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    step();
    we = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    raddr = a;
    #1;
    d = rdata;
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
    string       name;
  } rvec_t;

  rvec_t rtab[9];

  task automatic check_reset_table(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 9; i++) begin
      rd(rtab[i].addr, d);
      check({tag, rtab[i].name}, d, rtab[i].exp);
    end
    check({tag, "int_req"}, {31'b0, int_req}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [4:0]  alist[9];

    rtab[0] = '{5'd8,  32'h0000_0000, "badvaddr"};
    rtab[1] = '{5'd9,  32'h0000_0000, "count"};
    rtab[2] = '{5'd11, 32'h0000_0000, "compare"};
    rtab[3] = '{5'd12, 32'h0040_0000, "status"};
    rtab[4] = '{5'd13, 32'h0000_0000, "cause"};
    rtab[5] = '{5'd14, 32'h0000_0000, "epc"};
    rtab[6] = '{5'd15, 32'h004c_0102, "prid"};
    rtab[7] = '{5'd16, 32'h0000_8000, "config"};
    rtab[8] = '{5'd3,  32'h0000_0000, "unmapped"};

    idle();
    hw_int = 0;
    raddr  = 0;
    rst    = 1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    check_reset_table("rst_");

    // Timer match: TI and int_req exactly 10 cycles after the Count write
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    repeat (8) step();
    check("ti_early", {31'b0, cause_o[30]}, 32'h0);
    check("irq_early", {31'b0, int_req}, 32'h0);
    step();
    check("ti_match", {31'b0, cause_o[30]}, 32'h1);
    check("irq_timer", {31'b0, int_req}, 32'h1);
    rd(5'd9, d);
    check("count_at_match", d, 32'd5);
    step();
    check("ti_sticky", {31'b0, cause_o[30]}, 32'h1);
    mtc0(5'd11, 32'd5);
    check("ti_clear", {31'b0, cause_o[30]}, 32'h0);
    check("irq_clear", {31'b0, int_req}, 32'h0);

    // AdEL in a delay slot
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'hBFC0_0100; exc_bd = 1;
    exc_badvaddr = 32'h0000_1234;
    step();
    idle();
    check("exc_epc", epc_o, 32'hBFC0_00FC);
    check("exc_bd", {31'b0, cause_o[31]}, 32'h1);
    check("exc_code", {27'b0, cause_o[6:2]}, 32'd4);
    rd(5'd8, d);
    check("exc_badvaddr", d, 32'h0000_1234);
    check("exc_exl", {31'b0, status_o[1]}, 32'h1);

    // Nested exception while EXL=1 leaves EPC/BD alone
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h8000_0010; exc_bd = 0;
    step();
    idle();
    check("nest_epc", epc_o, 32'hBFC0_00FC);
    check("nest_bd", {31'b0, cause_o[31]}, 32'h1);
    check("nest_code", {27'b0, cause_o[6:2]}, 32'd8);

    // Exception + eret + mtc0 Status in one cycle
    exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h8000_0020; eret = 1;
    we = 1; waddr = 5'd12; wdata = 32'h0000_FF01;
    step();
    idle();
    check("prio_status", status_o, 32'h0040_FF03);
    check("prio_code", {27'b0, cause_o[6:2]}, 32'd12);
    check("prio_epc", epc_o, 32'hBFC0_00FC);

    eret = 1;
    step();
    eret = 0;
    check("eret_exl", {31'b0, status_o[1]}, 32'h0);

    // Hardware interrupt line 2 -> IP[4]
    mtc0(5'd12, 32'h0000_1001);
    hw_int = 6'b000100;
    #1;
    check("hw_pre_irq", {31'b0, int_req}, 32'h0);
    step();
    check("hw_ip4", {31'b0, cause_o[12]}, 32'h1);
    check("hw_irq", {31'b0, int_req}, 32'h1);
    hw_int = 0;
    step();
    check("hw_ip4_clr", {31'b0, cause_o[12]}, 32'h0);
    check("hw_irq_clr", {31'b0, int_req}, 32'h0);

    // Random traffic against the model
    alist = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      rst = ($urandom_range(0, 499) == 0);
      hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : hw_int;
      if ($urandom_range(0, 2) == 0) begin
        we = 1;
        waddr = alist[$urandom_range(0, 8)];
        if ($urandom_range(0, 7) == 0) waddr = 5'($urandom);
        wdata = $urandom;
        if (waddr == 5'd9 && $urandom_range(0, 3) != 0) waddr = 5'd12;
        if (waddr == 5'd11) wdata = m_count + 32'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 15) == 0) begin
        exc_valid = 1;
        exc_code = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
        exc_pc = $urandom;
        exc_bd = 1'($urandom);
        exc_badvaddr = $urandom;
      end
      eret = ($urandom_range(0, 9) == 0);
      step();
      check("rnd_status", status_o, m_status());
      check("rnd_cause", cause_o, m_cause());
      check("rnd_epc", epc_o, m_epc);
      check("rnd_irq", {31'b0, int_req}, {31'b0, m_int_req()});
      rd(5'($urandom_range(0, 17)), d);
      check("rnd_rdata", d, m_read(raddr));
    end

    // Mid-operation reset returns everything to reset values
    idle();
    rst = 0;
    mtc0(5'd12, 32'h0000_FF03);
    mtc0(5'd14, 32'h1234_5678);
    hw_int = 6'h3F;
    step();
    rst = 1;
    hw_int = 0;
    step();
    rst = 0;
    check_reset_table("rst2_");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
